// File: rtl/mux_arbiter.sv
// mux_arbiter: round-robin arbiter/sequencer in front of a shared WIDTH-bit 2:1 mux.
// Grants the path to requester A or B for a burst of beats and presents the selected
// data downstream through a valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req_a/b    request; held high for the whole burst (drop = abandon)
//   A, B       requester data
//   last_a/b   current beat is the final beat of the burst
//   out_ready  downstream accepts a beat this cycle
//   gnt_a/b    registered grant
//   S          registered mux select (0 = A, 1 = B)
//   Y          selected data, combinational
//   out_valid  owner is still requesting
//   busy       a grant is active
module mux_arbiter #(
   parameter int unsigned WIDTH     = 2,
   parameter int unsigned MAX_BURST = 4   // legal range 1..15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_a,
   input  logic             req_b,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             last_a,
   input  logic             last_b,
   input  logic             out_ready,
   output logic             gnt_a,
   output logic             gnt_b,
   output logic             S,
   output logic [WIDTH-1:0] Y,
   output logic             out_valid,
   output logic             busy
);

   localparam logic [3:0] MaxCnt = 4'(MAX_BURST);

   typedef enum logic [1:0] {StIdle, StGrantA, StGrantB} state_e;

   state_e     state_q, state_d;
   logic       s_q, s_d;
   logic [3:0] cnt_q, cnt_d;
   logic       ptr_b_q, ptr_b_d;   // 1 = B was served last, so A wins the next tie
   logic       gnt_a_q, gnt_a_d;
   logic       gnt_b_q, gnt_b_d;

   logic       is_a;
   logic       own_req;
   logic       own_last;
   logic       oth_req;
   logic       burst_end;
   logic [3:0] cnt_inc;

   // Owner-relative view so both grant states share one piece of logic.
   assign is_a     = (state_q == StGrantA);
   assign own_req  = is_a ? req_a  : req_b;
   assign own_last = is_a ? last_a : last_b;
   assign oth_req  = is_a ? req_b  : req_a;
   assign cnt_inc  = cnt_q + 4'd1;

   always_comb begin
      state_d   = state_q;
      s_d       = s_q;
      cnt_d     = cnt_q;
      ptr_b_d   = ptr_b_q;
      burst_end = 1'b0;

      case (state_q)
         StIdle: begin
            if (req_a && (!req_b || ptr_b_q)) begin
               state_d = StGrantA;
               s_d     = 1'b0;
            end else if (req_b) begin
               state_d = StGrantB;
               s_d     = 1'b1;
            end
         end
         StGrantA, StGrantB: begin
            if (!own_req) begin
               // Abandon: no beat, last is ignored.
               burst_end = 1'b1;
            end else if (out_ready) begin
               cnt_d = cnt_inc;
               if (own_last || (cnt_inc == MaxCnt)) begin
                  burst_end = 1'b1;
               end
            end

            if (burst_end) begin
               cnt_d   = 4'd0;
               ptr_b_d = !is_a;
               if (oth_req) begin
                  // Direct handoff, no idle bubble.
                  state_d = is_a ? StGrantB : StGrantA;
                  s_d     = is_a;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      gnt_a_d = (state_d == StGrantA);
      gnt_b_d = (state_d == StGrantB);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         s_q     <= 1'b0;
         cnt_q   <= 4'd0;
         ptr_b_q <= 1'b1;
         gnt_a_q <= 1'b0;
         gnt_b_q <= 1'b0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         cnt_q   <= cnt_d;
         ptr_b_q <= ptr_b_d;
         gnt_a_q <= gnt_a_d;
         gnt_b_q <= gnt_b_d;
      end
   end

   assign gnt_a     = gnt_a_q;
   assign gnt_b     = gnt_b_q;
   assign S         = s_q;
   assign Y         = s_q ? B : A;
   assign out_valid = (gnt_a_q & req_a) | (gnt_b_q & req_b);
   assign busy      = gnt_a_q | gnt_b_q;

endmodule

// File: tb/tb_mux_arbiter.sv
module tb_mux_arbiter;

   localparam int WIDTH     = 2;
   localparam int MAX_BURST = 4;

   logic             clk;
   logic             rst;
   logic             req_a, req_b;
   logic [WIDTH-1:0] A, B;
   logic             last_a, last_b;
   logic             out_ready;
   logic             gnt_a, gnt_b;
   logic             S;
   logic [WIDTH-1:0] Y;
   logic             out_valid;
   logic             busy;

   int checks   = 0;
   int failures = 0;

   mux_arbiter #(
      .WIDTH     (WIDTH),
      .MAX_BURST (MAX_BURST)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_a     (req_a),
      .req_b     (req_b),
      .A         (A),
      .B         (B),
      .last_a    (last_a),
      .last_b    (last_b),
      .out_ready (out_ready),
      .gnt_a     (gnt_a),
      .gnt_b     (gnt_b),
      .S         (S),
      .Y         (Y),
      .out_valid (out_valid),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input bit ga, input bit gb, input bit s,
                            input bit v, input bit bz, input logic [WIDTH-1:0] y);
      check({tag, " gnt_a"}, 32'(gnt_a), 32'(ga));
      check({tag, " gnt_b"}, 32'(gnt_b), 32'(gb));
      check({tag, " S"}, 32'(S), 32'(s));
      check({tag, " out_valid"}, 32'(out_valid), 32'(v));
      check({tag, " busy"}, 32'(busy), 32'(bz));
      check({tag, " Y"}, 32'(Y), 32'(y));
   endtask

   typedef struct packed {
      bit rst, ra, rb, la, lb, rdy;
      bit ga, gb, s, v, bz;
   } vec_t;

   vec_t tbl[33];

   // Reference model: who owns the path, beats so far, who was served last.
   int owner;     // 0 none, 1 A, 2 B
   int beats;
   int served;    // 1 A, 2 B
   bit sel;

   task automatic model_edge();
      bit rq[3];
      bit lt[3];
      int other;
      bit ended;
      rq[1] = req_a; rq[2] = req_b; rq[0] = 1'b0;
      lt[1] = last_a; lt[2] = last_b; lt[0] = 1'b0;
      if (rst) begin
         owner = 0; beats = 0; served = 2; sel = 1'b0;
      end else if (owner == 0) begin
         if (rq[1] && rq[2]) owner = (served == 1) ? 2 : 1;
         else if (rq[1]) owner = 1;
         else if (rq[2]) owner = 2;
         if (owner != 0) sel = (owner == 2);
      end else begin
         other = 3 - owner;
         ended = 1'b0;
         if (!rq[owner]) ended = 1'b1;
         else if (out_ready) begin
            beats = beats + 1;
            ended = lt[owner] || (beats == MAX_BURST);
         end
         if (ended) begin
            beats  = 0;
            served = owner;
            owner  = rq[other] ? other : 0;
            if (owner != 0) sel = (owner == 2);
         end
      end
   endtask

   initial begin
      logic [WIDTH-1:0] exp_y;
      bit exp_g[6];

      rst = 1'b1; req_a = 1'b0; req_b = 1'b0; last_a = 1'b0; last_b = 1'b0;
      out_ready = 1'b1; A = 2'b01; B = 2'b11;

      //          rst ra rb la lb rdy  ga gb s  v  bz
      tbl[0]  = '{1, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0};
      tbl[1]  = '{1, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0};
      tbl[2]  = '{0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0};
      tbl[3]  = '{0, 1, 0, 0, 0, 1,  1, 0, 0, 1, 1};
      tbl[4]  = '{0, 1, 0, 0, 0, 1,  1, 0, 0, 1, 1};
      tbl[5]  = '{0, 1, 0, 0, 0, 1,  1, 0, 0, 1, 1};
      tbl[6]  = '{0, 1, 0, 1, 0, 1,  0, 0, 0, 0, 0};
      tbl[7]  = '{0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0};
      tbl[8]  = '{0, 1, 1, 1, 1, 1,  0, 1, 1, 1, 1};
      tbl[9]  = '{0, 1, 1, 1, 1, 1,  1, 0, 0, 1, 1};
      tbl[10] = '{0, 1, 1, 1, 1, 1,  0, 1, 1, 1, 1};
      tbl[11] = '{0, 1, 1, 1, 1, 1,  1, 0, 0, 1, 1};
      tbl[12] = '{0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0};
      tbl[13] = '{0, 1, 0, 0, 0, 1,  1, 0, 0, 1, 1};
      tbl[14] = '{0, 1, 1, 0, 0, 1,  1, 0, 0, 1, 1};
      tbl[15] = '{0, 1, 1, 0, 0, 1,  1, 0, 0, 1, 1};
      tbl[16] = '{0, 1, 1, 0, 0, 1,  1, 0, 0, 1, 1};
      tbl[17] = '{0, 1, 1, 0, 0, 1,  0, 1, 1, 1, 1};
      tbl[18] = '{0, 0, 1, 0, 0, 1,  0, 1, 1, 1, 1};
      tbl[19] = '{0, 0, 1, 0, 0, 0,  0, 1, 1, 1, 1};
      tbl[20] = '{0, 0, 1, 0, 0, 0,  0, 1, 1, 1, 1};
      tbl[21] = '{0, 0, 1, 0, 0, 0,  0, 1, 1, 1, 1};
      tbl[22] = '{0, 0, 1, 0, 0, 1,  0, 1, 1, 1, 1};
      tbl[23] = '{0, 0, 1, 0, 0, 1,  0, 1, 1, 1, 1};
      tbl[24] = '{0, 0, 1, 0, 0, 1,  0, 0, 1, 0, 0};
      tbl[25] = '{0, 1, 0, 0, 0, 1,  1, 0, 0, 1, 1};
      tbl[26] = '{0, 1, 0, 0, 0, 1,  1, 0, 0, 1, 1};
      tbl[27] = '{0, 0, 1, 0, 0, 1,  0, 1, 1, 1, 1};
      tbl[28] = '{1, 0, 1, 0, 0, 1,  0, 0, 0, 0, 0};
      tbl[29] = '{0, 0, 1, 0, 0, 1,  0, 1, 1, 1, 1};
      tbl[30] = '{1, 1, 1, 0, 0, 1,  0, 0, 0, 0, 0};
      tbl[31] = '{0, 1, 1, 0, 0, 1,  1, 0, 0, 1, 1};
      tbl[32] = '{0, 1, 1, 1, 1, 1,  0, 1, 1, 1, 1};

      for (int i = 0; i < 33; i++) begin
         rst = tbl[i].rst; req_a = tbl[i].ra; req_b = tbl[i].rb;
         last_a = tbl[i].la; last_b = tbl[i].lb; out_ready = tbl[i].rdy;
         @(posedge clk);
         #1;
         exp_y = tbl[i].s ? 2'b11 : 2'b01;
         check_all($sformatf("vec%0d", i), tbl[i].ga, tbl[i].gb, tbl[i].s, tbl[i].v,
                   tbl[i].bz, exp_y);
      end

      // Capped burst with nobody else waiting: bubble through idle, then re-grant.
      rst = 1'b1; req_a = 1'b0; req_b = 1'b0; last_a = 1'b0; last_b = 1'b0; out_ready = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0; req_a = 1'b1;
      exp_g = '{1, 1, 1, 1, 0, 1};
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         check($sformatf("cap_regrant%0d gnt_a", i), 32'(gnt_a), 32'(exp_g[i]));
         check($sformatf("cap_regrant%0d busy", i), 32'(busy), 32'(exp_g[i]));
      end

      // Randomised run against the reference model.
      rst = 1'b1;
      @(posedge clk);
      model_edge();
      #1;
      for (int c = 0; c < 2000; c++) begin
         rst       = ($urandom_range(0, 39) == 0);
         req_a     = ($urandom_range(0, 9) < 7);
         req_b     = ($urandom_range(0, 9) < 6);
         last_a    = ($urandom_range(0, 3) == 0);
         last_b    = ($urandom_range(0, 3) == 0);
         out_ready = ($urandom_range(0, 3) != 0);
         A         = WIDTH'($urandom);
         B         = WIDTH'($urandom);
         @(posedge clk);
         model_edge();
         #1;
         exp_y = sel ? B : A;
         check_all($sformatf("rand%0d", c), owner == 1, owner == 2, sel,
                   ((owner == 1) && req_a) || ((owner == 2) && req_b), owner != 0, exp_y);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
